uart_core: RTL and testbench

Synthesizable 8N1 UART for the user project, the SoC-side counterpart of the serial terminal the testbench models. It serializes bytes from the firmware-facing register path onto `tx` and deserializes bytes arriving on `rx`, using a programmable bit period derived from the system clock. It sits between the Wishbone register decoder (which drives `clk_div`, `tx_start` and `tx_data`, and consumes `rx_data`) and the chip-level serial pins.

---
 rtl/uart_core.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// uart_core: 8N1 UART transmitter and receiver with a programmable bit period.
//
// Optional feature macro: UART_RX_FIFO_EN. When it is defined, received bytes
// go into a FIFO_DEPTH-entry FIFO. When it is not defined, they go into a
// single holding register.
//
// Parameters
//   DIV_W       width of clk_div
//   FIFO_DEPTH  RX FIFO entries, a power of two (only used with UART_RX_FIFO_EN)
//
// Ports
//   clk, rst_n    system clock; synchronous active-low reset
//   clk_div       bit period is clk_div+1 cycles; values below 3 act as 3
//   rx / tx       serial input (asynchronous) and output; both idle high
//   tx_start      request to send tx_data (taken only when the transmitter is free)
//   tx_data       byte to send
//   tx_busy       transmitter occupied
//   tx_done       one-cycle pulse at the end of the stop bit
//   rx_data       received byte; valid while rx_valid is high
//   rx_valid      a received byte is available
//   rx_ready      consumer takes rx_data this cycle
//   rx_frame_err  one-cycle pulse when the stop bit samples 0
//   rx_overrun    one-cycle pulse when a received byte is dropped
module uart_core #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             rx,
  output logic             tx,
  input  logic             tx_start,
  input  logic [7:0]       tx_data,
  output logic             tx_busy,
  output logic             tx_done,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_frame_err,
  output logic             rx_overrun
);

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  // Bit period minus one, with the divisor clamped to at least 3.
  function automatic logic [DIV_W-1:0] sat_pm1(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(3)) ? DIV_W'(3) : d;
  endfunction

  // floor(P/2), computed from P-1 so that it cannot overflow DIV_W bits.
  function automatic logic [DIV_W-1:0] half_period(input logic [DIV_W-1:0] pm1);
    return (pm1 >> 1) + {{(DIV_W-1){1'b0}}, pm1[0]};
  endfunction

  // ---------------- transmitter ----------------
  tx_state_t        tx_state, tx_state_nx;
  logic [DIV_W-1:0] tx_cnt, tx_cnt_nx, tx_pm1, tx_pm1_nx;
  logic [7:0]       tx_sr, tx_sr_nx;
  logic [2:0]       tx_idx, tx_idx_nx;
  logic             tx_nx, tx_busy_nx, tx_done_nx, tx_load, tx_tick;

  assign tx_tick = (tx_cnt == '0);

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_pm1_nx   = tx_pm1;
    tx_sr_nx    = tx_sr;
    tx_idx_nx   = tx_idx;
    tx_nx       = tx;
    tx_busy_nx  = tx_busy;
    tx_done_nx  = 1'b0;
    tx_load     = 1'b0;
    unique case (tx_state)
      T_IDLE: tx_load = tx_start;
      T_START: begin
        if (tx_tick) begin
          tx_state_nx = T_DATA;
          tx_nx       = tx_sr[0];
          tx_sr_nx    = {1'b1, tx_sr[7:1]};
          tx_idx_nx   = 3'd0;
          tx_cnt_nx   = tx_pm1;
        end else begin
          tx_cnt_nx = tx_cnt - 1'b1;
        end
      end
      T_DATA: begin
        if (tx_tick) begin
          tx_cnt_nx = tx_pm1;
          tx_idx_nx = tx_idx + 3'd1;
          if (tx_idx == 3'd7) begin
            tx_state_nx = T_STOP;
            tx_nx       = 1'b1;
          end else begin
            tx_nx    = tx_sr[0];
            tx_sr_nx = {1'b1, tx_sr[7:1]};
          end
        end else begin
          tx_cnt_nx = tx_cnt - 1'b1;
        end
      end
      T_STOP: begin
        if (tx_tick) begin
          tx_done_nx  = 1'b1;
          tx_state_nx = T_IDLE;
          tx_busy_nx  = 1'b0;
          // A request landing on the final stop-bit edge starts the next
          // frame immediately, so back-to-back frames have no idle gap.
          tx_load     = tx_start;
        end else begin
          tx_cnt_nx = tx_cnt - 1'b1;
        end
      end
      default: tx_state_nx = T_IDLE;
    endcase
    if (tx_load) begin
      tx_state_nx = T_START;
      tx_nx       = 1'b0;
      tx_busy_nx  = 1'b1;
      tx_sr_nx    = tx_data;
      tx_pm1_nx   = sat_pm1(clk_div);
      tx_cnt_nx   = sat_pm1(clk_div);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_idx   <= tx_idx_nx;
      tx       <= tx_nx;
      tx_busy  <= tx_busy_nx;
      tx_done  <= tx_done_nx;
    end
  end

  always_ff @(posedge clk) begin
    tx_sr  <= tx_sr_nx;
    tx_pm1 <= tx_pm1_nx;
  end

  // ---------------- receiver: synchronizer ----------------
  logic rx_p0, rx_p1, rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  // ---------------- receiver: framing ----------------
  rx_state_t        rx_state, rx_state_nx;
  logic [DIV_W-1:0] rx_cnt, rx_cnt_nx, rx_pm1, rx_pm1_nx;
  logic [7:0]       rx_sr, rx_sr_nx;
  logic [2:0]       rx_idx, rx_idx_nx;
  logic             rx_wr, rx_ferr_nx, rx_tick;

  assign rx_tick = (rx_cnt == '0);

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_pm1_nx   = rx_pm1;
    rx_sr_nx    = rx_sr;
    rx_idx_nx   = rx_idx;
    rx_wr       = 1'b0;
    rx_ferr_nx  = 1'b0;
    unique case (rx_state)
      R_IDLE: begin
        if (!rx_s) begin
          rx_state_nx = R_START;
          rx_pm1_nx   = sat_pm1(clk_div);
          rx_cnt_nx   = half_period(sat_pm1(clk_div));
        end
      end
      R_START: begin
        if (rx_tick) begin
          // Line back high at mid start bit: treat as a glitch.
          rx_state_nx = rx_s ? R_IDLE : R_DATA;
          rx_cnt_nx   = rx_pm1;
          rx_idx_nx   = 3'd0;
        end else begin
          rx_cnt_nx = rx_cnt - 1'b1;
        end
      end
      R_DATA: begin
        if (rx_tick) begin
          rx_sr_nx  = {rx_s, rx_sr[7:1]};
          rx_cnt_nx = rx_pm1;
          rx_idx_nx = rx_idx + 3'd1;
          if (rx_idx == 3'd7) rx_state_nx = R_STOP;
        end else begin
          rx_cnt_nx = rx_cnt - 1'b1;
        end
      end
      R_STOP: begin
        if (rx_tick) begin
          // Back to idle at mid stop bit so the next start edge is caught.
          rx_state_nx = R_IDLE;
          rx_wr       = rx_s;
          rx_ferr_nx  = !rx_s;
        end else begin
          rx_cnt_nx = rx_cnt - 1'b1;
        end
      end
      default: rx_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state     <= R_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_state     <= rx_state_nx;
      rx_cnt       <= rx_cnt_nx;
      rx_idx       <= rx_idx_nx;
      rx_frame_err <= rx_ferr_nx;
    end
  end

  always_ff @(posedge clk) begin
    rx_sr  <= rx_sr_nx;
    rx_pm1 <= rx_pm1_nx;
  end

  // ---------------- receiver: storage ----------------
`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, rd;

  // Pointers carry one extra wrap bit: equal low bits with different wrap
  // bits means full, identical pointers mean empty.
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rx_valid = (wptr != rptr);
  assign rx_data  = mem[rptr[AW-1:0]];
  assign rd       = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      rx_overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      rx_overrun <= rx_wr && full && !rd;
      if (rx_wr && (!full || rd)) begin
        mem[wptr[AW-1:0]] <= rx_sr;
        wptr              <= wptr + 1'b1;
      end
      if (rd) rptr <= rptr + 1'b1;
    end
  end
`else
  // Depth only matters for the FIFO build.
  localparam int unused_fifo_depth = FIFO_DEPTH;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_wr) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_sr;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: scoreboard bench for uart_core at clk_div=15 (16 cycles/bit).
// Stimulus pushes expected events (transmitted bytes, received bytes, frame
// errors, overruns) into queues; monitor processes pop and compare whenever
// the DUT presents the corresponding output.
module tb_uart_core;
  localparam int DIV_W = 16;
  localparam int BITP  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DIV_W-1:0] clk_div;
  logic             rx;
  logic             tx;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;
  logic             tx_done;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             rx_frame_err;
  logic             rx_overrun;

  always #5 clk = ~clk;

  uart_core #(.DIV_W(DIV_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .rx(rx), .tx(tx),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  int checks   = 0;
  int failures = 0;
  int n_done   = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;

  byte unsigned q_tx[$];
  byte unsigned q_rx[$];
  int           q_ferr[$];
  int           q_ovr[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // RX-side monitor: consumed bytes, frame errors, overruns.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        if (q_rx.size() == 0) unexpected("rx_byte_unexpected");
        else chk("rx_data", rx_data, q_rx.pop_front());
      end
      if (rx_frame_err) begin
        n_ferr++;
        if (q_ferr.size() == 0) unexpected("rx_frame_err_unexpected");
        else void'(q_ferr.pop_front());
      end
      if (rx_overrun) begin
        n_ovr++;
        if (q_ovr.size() == 0) unexpected("rx_overrun_unexpected");
        else void'(q_ovr.pop_front());
      end
      if (tx_done) n_done++;
    end
  end

  // TX line monitor: every bit must hold for exactly BITP samples with
  // tx_busy high throughout; tx_done must be seen right after the 10th bit.
  int         tm_cnt = -1;
  logic [9:0] tm_bits;
  bit         tm_bad;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      tm_cnt = -1;
    end else begin
      if (tm_cnt < 0 && tx == 1'b0) begin
        tm_cnt = 0;
        tm_bad = 1'b0;
      end
      if (tm_cnt >= 0) begin
        if (tm_cnt < 10 * BITP) begin
          if (tm_cnt % BITP == 0) tm_bits[tm_cnt / BITP] = tx;
          else if (tx !== tm_bits[tm_cnt / BITP]) tm_bad = 1'b1;
          if (tx_busy !== 1'b1) tm_bad = 1'b1;
          tm_cnt++;
        end else begin
          chk("tx_done_at_frame_end", tx_done, 1);
          chk("tx_busy_at_frame_end", tx_busy, 0);
          chk("tx_bit_timing_bad", tm_bad, 0);
          chk("tx_start_bit", tm_bits[0], 0);
          chk("tx_stop_bit", tm_bits[9], 1);
          if (q_tx.size() == 0) unexpected("tx_frame_unexpected");
          else chk("tx_byte", tm_bits[8:1], q_tx.pop_front());
          tm_cnt = -1;
        end
      end
    end
  end

  task automatic send_tx(input byte unsigned d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < 12 * BITP; i++) begin
      @(negedge clk);
      if (!tx_busy) return;
    end
    unexpected("tx_busy_timeout");
  endtask

  // Drives one frame on rx, 16 cycles per bit; returns at the end of the stop bit.
  task automatic send_rx(input byte unsigned d, input bit stop, input bit chk_early);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = f[i];
      if (i == 9 && chk_early) chk("rx_valid_before_stop", rx_valid, 0);
      repeat (BITP - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    logic [9:0] f;
    rst_n    = 1'b0;
    rx       = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b0;
    clk_div  = 16'd15;
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset_tx", tx, 1);
    chk("reset_tx_busy", tx_busy, 0);
    chk("reset_tx_done", tx_done, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_frame_err", rx_frame_err, 0);
    chk("reset_rx_overrun", rx_overrun, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // TX 0xA5, plus an ignored request while busy
    q_tx.push_back(8'hA5);
    send_tx(8'hA5);
    chk("tx_low_after_start", tx, 0);
    chk("tx_busy_after_start", tx_busy, 1);
    repeat (40) @(negedge clk);
    send_tx(8'h77);
    wait_tx_idle();
    repeat (3 * BITP) @(negedge clk);
    chk("tx_done_count_1", n_done, 1);
    chk("tx_queue_drained_1", q_tx.size(), 0);
    chk("tx_idle_line", tx, 1);

    // RX 0x3C held, then one-cycle ready
    rx_ready = 1'b0;
    q_rx.push_back(8'h3C);
    send_rx(8'h3C, 1'b1, 1'b1);
    chk("rx_valid_after_frame", rx_valid, 1);
    chk("rx_data_after_frame", rx_data, 8'h3C);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("rx_valid_cleared", rx_valid, 0);
    chk("rx_queue_drained_1", q_rx.size(), 0);

    // Glitch then frame error
    rx_ready = 1'b1;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_rx_valid", rx_valid, 0);
    chk("glitch_frame_err_count", n_ferr, 0);
    q_ferr.push_back(1);
    send_rx(8'h55, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("frame_err_count", n_ferr, 1);
    chk("frame_err_rx_valid", rx_valid, 0);
    chk("frame_err_queue_drained", q_ferr.size(), 0);

`ifdef UART_RX_FIFO_EN
    // FIFO fills with 0x01..0x04; 0x05 overruns
    rx_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) q_rx.push_back(8'(b));
      else q_ovr.push_back(1);
      send_rx(8'(b), 1'b1, 1'b0);
    end
    repeat (4) @(negedge clk);
    chk("fifo_overrun_count", n_ovr, 1);
    chk("fifo_head", rx_data, 8'h01);
    @(negedge clk);
    rx_ready = 1'b1;
    repeat (6) @(negedge clk);
    rx_ready = 1'b0;
    chk("fifo_empty_after_drain", rx_valid, 0);
    chk("fifo_queue_drained", q_rx.size(), 0);
    chk("fifo_overrun_queue_drained", q_ovr.size(), 0);
`else
    // Holding register overrun: 0x11 kept, 0x22 dropped
    rx_ready = 1'b0;
    q_rx.push_back(8'h11);
    send_rx(8'h11, 1'b1, 1'b0);
    q_ovr.push_back(1);
    send_rx(8'h22, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("overrun_count", n_ovr, 1);
    chk("overrun_kept_data", rx_data, 8'h11);
    chk("overrun_rx_valid", rx_valid, 1);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    chk("overrun_rx_valid_cleared", rx_valid, 0);
    chk("overrun_queue_drained", q_rx.size(), 0);
    chk("overrun_ovr_queue_drained", q_ovr.size(), 0);
`endif

    // Reset mid-frame: TX in data bit 3, RX in data bit 4
    rx_ready = 1'b1;
    f = {1'b1, 8'h3C, 1'b0};
    @(negedge clk);
    rx = 1'b0;
    for (int t = 1; t <= 85; t++) begin
      @(negedge clk);
      rx = f[t / BITP];
      if (t == 16) begin
        tx_data  = 8'h96;
        tx_start = 1'b1;
      end
      if (t == 17) tx_start = 1'b0;
      if (t == 85) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    rx    = 1'b1;
    chk("midreset_tx", tx, 1);
    chk("midreset_tx_busy", tx_busy, 0);
    chk("midreset_rx_valid", rx_valid, 0);
    repeat (2 * BITP) @(negedge clk);
    chk("midreset_no_done", n_done, 1);

    // Clean frames after reset
    q_tx.push_back(8'h5A);
    send_tx(8'h5A);
    wait_tx_idle();
    q_rx.push_back(8'hC3);
    send_rx(8'hC3, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("post_reset_tx_done_count", n_done, 2);
    chk("post_reset_tx_queue", q_tx.size(), 0);
    chk("post_reset_rx_queue", q_rx.size(), 0);
    chk("post_reset_ferr_count", n_ferr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
